// File: rtl/gf_pkg.sv
// Shared constants and state type for the GF(2^m) arithmetic blocks.
package gf_pkg;

    localparam int unsigned GF_M            = 16;
    localparam int unsigned GF_CNT_W        = $clog2(GF_M);
    // x^16 + x^5 + x^3 + x + 1, x^16 term implicit
    localparam logic [GF_M-1:0] GF_POLY_DEFAULT = 16'h002B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gf_state_e;

endpackage : gf_pkg

// File: rtl/gf_xtime.sv
// Combinational multiply-by-x in GF(2^M): y = a*x mod (x^M + g).
// Ports:
//   a : operand, a[1] is the x^0 coefficient
//   g : reduction polynomial without the x^M term, g[1] is x^0
//   y : a*x reduced
module gf_xtime
    import gf_pkg::*;
#(
    parameter int unsigned M = GF_M
) (
    input  logic [M:1] a,
    input  logic [M:1] g,
    output logic [M:1] y
);

    // Shift toward higher degree; the x^M term that falls off folds back as g.
    assign y = {a[M-1:1], 1'b0} ^ ({M{a[M]}} & g);

endmodule : gf_xtime

// File: rtl/gf_lsb_serial_mult.sv
// Bit-serial GF(2^M) multiplier, multiplier operand scanned LSB-first.
// One multiplier bit per cycle: conditionally accumulate A, then A <= A*x mod g.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   a, b, g             : multiplicand, multiplier, reduction poly (bit 1 = x^0)
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   p                   : a*b mod (x^M + g), held until the next completion
module gf_lsb_serial_mult
    import gf_pkg::*;
#(
    parameter int unsigned M = GF_M
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [M:1] a,
    input  logic [M:1] b,
    input  logic [M:1] g,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [M:1] p
);

    localparam int unsigned CNT_W = (M > 1) ? $clog2(M) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(M - 1);

    gf_state_e       state_q, state_d;
    logic [M:1]      a_q, a_d;
    logic [M:1]      b_q, b_d;
    logic [M:1]      g_q, g_d;
    logic [M:1]      acc_q, acc_d;
    logic [M:1]      p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [M:1]      a_xt;
    logic [M:1]      acc_next;

    gf_xtime #(.M(M)) u_xtime (
        .a (a_q),
        .g (g_q),
        .y (a_xt)
    );

    // Partial product for the current multiplier bit.
    assign acc_next = acc_q ^ ({M{b_q[1]}} & a_q);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            g_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            g_q     <= g_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        g_d     = g_q;
        acc_d   = acc_q;
        p_d     = p_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    g_d     = g;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_next;
                a_d   = a_xt;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Last multiplier bit: publish result, park the counter.
                    p_d     = acc_next;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake flags are direct decodes of the state register.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign p         = p_q;

endmodule : gf_lsb_serial_mult

// File: tb/tb_gf_lsb_serial_mult.sv
// Self-checking bench for gf_lsb_serial_mult: polynomial-arithmetic reference
// model with a per-cycle compare, plus directed vectors with literal results.
module tb_gf_lsb_serial_mult;

    localparam int unsigned M = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [M:1] a = '0;
    logic [M:1] b = '0;
    logic [M:1] g = 16'h002B;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [M:1] p;

    int checks = 0;
    int failures = 0;

    gf_lsb_serial_mult #(.M(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .g         (g),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: full carry-less product, then long division by x^16 + g.
    function automatic logic [15:0] gf_mul(input logic [15:0] x, input logic [15:0] y,
                                           input logic [15:0] pg);
        logic [31:0] prod;
        prod = '0;
        for (int i = 0; i < 16; i++)
            if (y[i]) prod ^= 32'(x) << i;
        for (int i = 31; i >= 16; i--)
            if (prod[i]) prod ^= {15'b0, 1'b1, pg} << (i - 16);
        return prod[15:0];
    endfunction

    // Transaction-level model: 0 idle, 1 busy, 2 result presented.
    int         m_phase = 0;
    int         m_cnt = 0;
    logic [M:1] m_p = '0;
    logic [M:1] m_exp = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_cnt   = 0;
            m_p     = '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_exp   = gf_mul(a, b, g);
                    m_cnt   = 0;
                    m_phase = 1;
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == M) begin
                        m_p     = m_exp;
                        m_phase = 2;
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("cyc_out_valid", 32'(out_valid), 32'(m_phase == 2));
        check("cyc_in_ready",  32'(in_ready),  32'(m_phase == 0));
        check("cyc_p",         32'(p),         32'(m_p));
    end

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 32'(out_valid), 32'd1);
    endtask

    // One operation; g is scrambled right after accept to prove it was captured.
    task automatic run_op(input logic [M:1] ta, input logic [M:1] tb_v, input logic [M:1] tg,
                          input logic [M:1] exp, input string name);
        int lat;
        @(posedge clk); #1;
        check({name, "_ready"}, 32'(in_ready), 32'd1);
        a = ta; b = tb_v; g = tg; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        g = ~tg;
        wait_done(lat);
        check({name, "_lat"}, 32'(lat), 32'd16);
        check({name, "_p"}, 32'(p), 32'(exp));
    endtask

    initial begin
        int lat;
        int e;
        int seen;
        logic [M:1] sp;

        #2 rst_n = 1'b0;
        in_valid = 1'b1;
        a = 16'h0001; b = 16'h0001;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_p", 32'(p), 32'd0);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;

        // Pin the reference model to hand-computed products.
        check("model_1x1",   32'(gf_mul(16'h0001, 16'h0001, 16'h002B)), 32'h0001);
        check("model_red",   32'(gf_mul(16'h8000, 16'h0002, 16'h002B)), 32'h002B);
        check("model_c10e",  32'(gf_mul(16'h8000, 16'h8000, 16'h002B)), 32'hC10E);
        check("model_3x5",   32'(gf_mul(16'h0003, 16'h0005, 16'h002B)), 32'h000F);

        run_op(16'h0001, 16'h0001, 16'h002B, 16'h0001, "one");
        run_op(16'h8000, 16'h0002, 16'h002B, 16'h002B, "reduce");
        run_op(16'h8000, 16'h8000, 16'h002B, 16'hC10E, "rep_reduce");
        run_op(16'h0000, 16'hBEEF, 16'h002B, 16'h0000, "a_zero");

        // Back-to-back issue with out_ready tied high and in_valid held.
        @(posedge clk); #1;
        a = 16'h0003; b = 16'h0005; g = 16'h002B; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        a = 16'h1234; b = 16'h0000;
        wait_done(lat);
        check("b2b1_lat", 32'(lat), 32'd16);
        check("b2b1_p", 32'(p), 32'h000F);
        e = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (!in_ready && !out_valid) begin
                e = k;
                break;
            end
        end
        check("b2b_accept_gap", 32'(e), 32'd2);
        in_valid = 1'b0;
        wait_done(lat);
        check("b2b2_lat", 32'(lat), 32'd16);
        check("b2b2_p", 32'(p), 32'h0000);

        // Back-pressure in DONE with new operands already offered.
        @(posedge clk); #1;
        out_ready = 1'b0;
        a = 16'h1234; b = 16'h5678; g = 16'h002B; in_valid = 1'b1;
        @(posedge clk); #1;
        wait_done(lat);
        check("stall_lat", 32'(lat), 32'd16);
        sp = gf_mul(16'h1234, 16'h5678, 16'h002B);
        check("stall_p", 32'(p), 32'(sp));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("stall_hold_valid", 32'(out_valid), 32'd1);
            check("stall_hold_ready", 32'(in_ready), 32'd0);
            check("stall_hold_p", 32'(p), 32'(sp));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release_idle", 32'(in_ready), 32'd1);
        check("stall_release_ov", 32'(out_valid), 32'd0);
        check("stall_retain_p", 32'(p), 32'(sp));
        @(posedge clk); #1;
        check("stall_second_accept", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_done(lat);
        check("stall2_lat", 32'(lat), 32'd16);
        check("stall2_p", 32'(p), 32'(sp));

        // Asynchronous abort seven cycles into RUN.
        @(posedge clk); #1;
        a = 16'h8000; b = 16'h8000; g = 16'h002B; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_p", 32'(p), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        run_op(16'h00FF, 16'h0101, 16'h002B, 16'hFFFF, "post_abort");
        run_op(16'h8000, 16'h0002, 16'h1021, 16'h1021, "alt_poly");

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_gf_lsb_serial_mult
